// File: rtl/roi_area_stats_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// roi_area_stats_pkg : shared field layout and default widths
// Rev 1.0
// ----------------------------------------------------------------------
package roi_area_stats_pkg;

  localparam int c_DEF_CW = 12;
  localparam int c_DEF_AW = 20;

  // Field slots within one channel word, {v_r, v_l, h_r, h_l} from MSB down.
  // The bbox word reuses the same slots for {max_v, min_v, max_h, min_h}.
  localparam int c_FLD_H_L = 0;
  localparam int c_FLD_H_R = 1;
  localparam int c_FLD_V_L = 2;
  localparam int c_FLD_V_R = 3;
  localparam int c_NUM_FLD = 4;

  function automatic int fld_lsb(input int fld, input int cw);
    return fld * cw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/roi_area_ch.sv
`default_nettype none
// ----------------------------------------------------------------------
// roi_area_ch : one window - shadow bounds, area/saturation, bbox, latch
// Rev 1.0
// ----------------------------------------------------------------------
module roi_area_ch
  import roi_area_stats_pkg::*;
#(
  parameter int CW        = c_DEF_CW,
  parameter int AW        = c_DEF_AW,
  parameter int MATCH_VAL = 0,
  parameter int STRICT    = 1
) (
  input  logic                  pixelclk,
  input  logic                  reset_n,
  input  logic                  frame,
  input  logic                  pix_valid,
  input  logic                  wb,
  input  logic [CW-1:0]         h,
  input  logic [CW-1:0]         v,
  input  logic [c_NUM_FLD*CW-1:0] bounds,
  output logic [AW-1:0]         area,
  output logic [c_NUM_FLD*CW-1:0] bbox,
  output logic                  bbox_valid,
  output logic                  area_sat
);

  localparam int c_HL = fld_lsb(c_FLD_H_L, CW);
  localparam int c_HR = fld_lsb(c_FLD_H_R, CW);
  localparam int c_VL = fld_lsb(c_FLD_V_L, CW);
  localparam int c_VR = fld_lsb(c_FLD_V_R, CW);
  localparam logic          c_MATCH   = 1'(MATCH_VAL);
  localparam logic [AW-1:0] c_ACC_MAX = {AW{1'b1}};

  logic [CW-1:0]           r_h_l, r_h_r, r_v_l, r_v_r;
  logic [AW-1:0]           r_acc;
  logic                    r_seen, r_sat;
  logic [CW-1:0]           r_min_h, r_max_h, r_min_v, r_max_v;
  logic [AW-1:0]           r_lat_area;
  logic [c_NUM_FLD*CW-1:0] r_lat_bbox;
  logic                    r_lat_valid, r_lat_sat;
  logic                    w_match;

  function automatic logic in_span(input logic [CW-1:0] x, input logic [CW-1:0] lo,
                                   input logic [CW-1:0] hi);
    return (STRICT != 0) ? ((lo < x) && (x < hi)) : ((lo <= x) && (x <= hi));
  endfunction

  assign w_match = pix_valid && !frame && (wb == c_MATCH) &&
                   in_span(h, r_h_l, r_h_r) && in_span(v, r_v_l, r_v_r);

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_l       <= '0;
      r_h_r       <= '0;
      r_v_l       <= '0;
      r_v_r       <= '0;
      r_acc       <= '0;
      r_seen      <= 1'b0;
      r_sat       <= 1'b0;
      r_min_h     <= '0;
      r_max_h     <= '0;
      r_min_v     <= '0;
      r_max_v     <= '0;
      r_lat_area  <= '0;
      r_lat_bbox  <= '0;
      r_lat_valid <= 1'b0;
      r_lat_sat   <= 1'b0;
    end else if (frame) begin
      // Trackers are cleared to zero, so an empty channel latches a zero bbox.
      r_lat_area  <= r_acc;
      r_lat_bbox  <= {r_max_v, r_min_v, r_max_h, r_min_h};
      r_lat_valid <= r_seen;
      r_lat_sat   <= r_sat;
      r_acc       <= '0;
      r_seen      <= 1'b0;
      r_sat       <= 1'b0;
      r_min_h     <= '0;
      r_max_h     <= '0;
      r_min_v     <= '0;
      r_max_v     <= '0;
      r_h_l       <= bounds[c_HL +: CW];
      r_h_r       <= bounds[c_HR +: CW];
      r_v_l       <= bounds[c_VL +: CW];
      r_v_r       <= bounds[c_VR +: CW];
    end else if (w_match) begin
      if (r_acc == c_ACC_MAX) r_sat <= 1'b1;
      else                    r_acc <= r_acc + 1'b1;
      if (!r_seen) begin
        r_seen  <= 1'b1;
        r_min_h <= h;
        r_max_h <= h;
        r_min_v <= v;
        r_max_v <= v;
      end else begin
        if (h < r_min_h) r_min_h <= h;
        if (h > r_max_h) r_max_h <= h;
        if (v < r_min_v) r_min_v <= v;
        if (v > r_max_v) r_max_v <= v;
      end
    end
  end

  assign area       = r_lat_area;
  assign bbox       = r_lat_bbox;
  assign bbox_valid = r_lat_valid;
  assign area_sat   = r_lat_sat;

endmodule
`default_nettype wire

// File: rtl/roi_area_stats.sv
`default_nettype none
// ----------------------------------------------------------------------
// roi_area_stats : multi-window binary-pixel area and bounding-box stats
// Rev 1.0
// ----------------------------------------------------------------------
module roi_area_stats
  import roi_area_stats_pkg::*;
#(
  parameter int NUM_ROI   = 4,
  parameter int CW        = c_DEF_CW,
  parameter int AW        = c_DEF_AW,
  parameter int MATCH_VAL = 0,
  parameter int STRICT    = 1
) (
  input  logic                            pixelclk,
  input  logic                            reset_n,
  input  logic                            i_vsync_pos,
  input  logic                            pix_valid,
  input  logic                            wb,
  input  logic [CW-1:0]                   hcount,
  input  logic [CW-1:0]                   vcount,
  input  logic [NUM_ROI*c_NUM_FLD*CW-1:0] roi_bounds,
  output logic [NUM_ROI*AW-1:0]           area,
  output logic [NUM_ROI*c_NUM_FLD*CW-1:0] bbox,
  output logic [NUM_ROI-1:0]              bbox_valid,
  output logic [NUM_ROI-1:0]              area_sat,
  output logic                            frame_done
);

  localparam int c_CH_W = c_NUM_FLD * CW;

  logic          r_valid, r_wb, r_vsync, r_frame_done;
  logic [CW-1:0] r_h, r_v;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid      <= 1'b0;
      r_wb         <= 1'b0;
      r_vsync      <= 1'b0;
      r_h          <= '0;
      r_v          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= pix_valid;
      r_wb         <= wb;
      r_vsync      <= i_vsync_pos;
      r_h          <= hcount;
      r_v          <= vcount;
      // Channels latch on the same edge, so results and pulse appear together.
      r_frame_done <= r_vsync;
    end
  end

  assign frame_done = r_frame_done;

  generate
    for (genvar k = 0; k < NUM_ROI; k++) begin : g_ch
      roi_area_ch #(
        .CW        (CW),
        .AW        (AW),
        .MATCH_VAL (MATCH_VAL),
        .STRICT    (STRICT)
      ) u_ch (
        .pixelclk   (pixelclk),
        .reset_n    (reset_n),
        .frame      (r_vsync),
        .pix_valid  (r_valid),
        .wb         (r_wb),
        .h          (r_h),
        .v          (r_v),
        .bounds     (roi_bounds[k*c_CH_W +: c_CH_W]),
        .area       (area[k*AW +: AW]),
        .bbox       (bbox[k*c_CH_W +: c_CH_W]),
        .bbox_valid (bbox_valid[k]),
        .area_sat   (area_sat[k])
      );
    end
  endgenerate

endmodule
`default_nettype wire
